// File: rtl/load_store_unit.sv
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Single-outstanding load/store initiator for the data memory.
//             Optional store read-back verification: define LSU_READBACK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 4,
    parameter int INIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int c_cnt_w = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_init_last = c_cnt_w'(INIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_WR    = 3'd2,
        S_RD    = 3'd3,
        S_RWAIT = 3'd4,
        S_RESP  = 3'd5
`ifdef LSU_READBACK_EN
        ,
        S_VRD   = 3'd6,
        S_VWAIT = 3'd7
`endif
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_init_cnt;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [DATA_W-1:0]   r_mem_write_data;
    logic                r_mem_we;
    logic                r_mem_re;
`ifdef LSU_READBACK_EN
    logic                r_rsp_err;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_INIT;
            r_init_cnt       <= '0;
            r_req_ready      <= 1'b0;
            r_rsp_valid      <= 1'b0;
            r_rsp_rdata      <= '0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
            r_mem_we         <= 1'b0;
            r_mem_re         <= 1'b0;
`ifdef LSU_READBACK_EN
            r_rsp_err        <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_init_cnt == c_init_last) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + c_cnt_w'(1);
                    end
                end
                S_IDLE: begin
                    // The request is captured here; the FSM path encodes its direction.
                    if (req_valid && r_req_ready) begin
                        r_req_ready      <= 1'b0;
                        r_mem_address    <= req_addr;
                        r_mem_write_data <= req_wdata;
                        if (req_write) begin
                            r_state  <= S_WR;
                            r_mem_we <= 1'b1;
                        end else begin
                            r_state  <= S_RD;
                            r_mem_re <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    r_mem_we <= 1'b0;
`ifdef LSU_READBACK_EN
                    r_state  <= S_VRD;
                    r_mem_re <= 1'b1;
`else
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
`endif
                end
                S_RD: begin
                    r_mem_re <= 1'b0;
                    r_state  <= S_RWAIT;
                end
                S_RWAIT: begin
                    r_rsp_rdata <= mem_read_data;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
`ifdef LSU_READBACK_EN
                S_VRD: begin
                    r_mem_re <= 1'b0;
                    r_state  <= S_VWAIT;
                end
                S_VWAIT: begin
                    r_rsp_rdata <= mem_read_data;
                    r_rsp_err   <= (mem_read_data != r_mem_write_data);
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
`endif
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
`ifdef LSU_READBACK_EN
                    r_rsp_err   <= 1'b0;
`endif
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state     <= S_INIT;
                    r_init_cnt  <= '0;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready        = r_req_ready;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_rdata        = r_rsp_rdata;
    assign mem_address      = r_mem_address;
    assign mem_write_data   = r_mem_write_data;
    assign mem_write_enable = r_mem_we;
    assign mem_read_enable  = r_mem_re;
`ifdef LSU_READBACK_EN
    assign rsp_err          = r_rsp_err;
`else
    assign rsp_err          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-side initiator for the 4-bit CPU's data memory. Accepts one load or store request at a time from the control unit over a valid/ready handshake. Drives the memory's address, write-data, write-enable and read-enable lines, and returns load data with a one-cycle response pulse. It sits between the control unit / register file and the data memory, and is the only block that drives the memory's request lines.

## Interface
- ADDR_W, 4, memory address width (16 slots)
- DATA_W, 4, data width
- INIT_CYCLES, 2, cycles after reset release during which no request is accepted (covers memory clear); minimum 1
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; one clock domain
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_addr  input  ADDR_W  target slot
- req_wdata  input  DATA_W  store data
- rsp_valid  output  1  one-cycle completion pulse, loads and stores
- rsp_rdata  output  DATA_W  load result / read-back value
- rsp_err  output  1  read-back mismatch (LSU_READBACK_EN only, else constant 0)
- mem_address  output  ADDR_W  to memory address
- mem_write_data  output  DATA_W  to memory write data
- mem_write_enable  output  1  to memory write enable
- mem_read_enable  output  1  to memory read enable
- mem_read_data  input  DATA_W  from memory, registered there, valid the cycle after read_enable

## Operation
- The FSM has the states INIT, IDLE, WR, RD, RWAIT and RESP. With LSU_READBACK_EN it adds VRD and VWAIT.
- All outputs are registered. During reset, and on its release, every output is 0. The FSM enters INIT with its counter cleared.
- INIT: req_ready=0. After INIT_CYCLES edges the FSM goes to IDLE. req_valid is ignored.
- IDLE: req_ready=1. A request is accepted on an edge with req_valid && req_ready. req_write, req_addr and req_wdata are latched on that edge; later input changes have no effect on the access.
- Store: IDLE→WR→RESP→IDLE.
- Load: IDLE→RD→RWAIT→RESP→IDLE.
- mem_write_enable and mem_read_enable are never 1 in the same cycle. Each is high for exactly one cycle per access.
- mem_address and mem_write_data hold the latched values from WR/RD through RESP, and are 0 in INIT.
- rsp_rdata is captured from mem_read_data on the RWAIT→RESP edge. It holds until the next capture. Stores do not change it unless LSU_READBACK_EN is defined.
- There is no pipelining: req_ready is 0 in every state except IDLE.
- Asynchronous reset mid-access: the FSM returns to INIT immediately and all outputs go to 0. The in-flight request is dropped with no rsp_valid. A store whose WR cycle was already sampled by memory remains written.

## Timing
- Cycle 0 is the accept cycle (req_valid && req_ready).
- Store:
  - cycle 1: mem_write_enable=1; memory writes at the end of cycle 1.
  - cycle 2: rsp_valid=1.
  - cycle 3: req_ready=1. Latency is 2 cycles.
- Load:
  - cycle 1: mem_read_enable=1.
  - cycle 2: enables 0, mem_read_data valid, captured at the end of the cycle.
  - cycle 3: rsp_valid=1 and rsp_rdata valid.
  - cycle 4: req_ready=1. Latency is 3 cycles.
- After reset deasserts, req_ready first rises INIT_CYCLES cycles later.
- req_valid held across the RESP cycle is accepted only in IDLE, never in RESP.

## Configuration
- LSU_READBACK_EN defined: every store is verified.
  - Path: WR→VRD (mem_read_enable=1)→VWAIT (compare mem_read_data with the latched wdata)→RESP.
  - In RESP: rsp_err=1 if they differ, rsp_rdata=read-back value. Store latency becomes 4 cycles.
  - rsp_err is 0 for loads and is valid only with rsp_valid, 0 otherwise.
- LSU_READBACK_EN undefined: the VRD/VWAIT states do not exist. Stores follow the base path and rsp_err is tied to 0.

## Test plan
- Reset then idle: assert reset mid-cycle → all outputs 0 asynchronously. req_ready rises INIT_CYCLES=2 cycles after release, and req_valid during INIT is ignored.
- Store then load: store addr 5 data 0xA, then load addr 5 → store rsp_valid at cycle 2. Load rsp_valid at cycle 3 with rsp_rdata=0xA, and the enables are never both 1.
- Post-reset clear: load addr 15 after reset → rsp_rdata=0x0.
- Back-to-back requests with req_valid held high: store addr 3 data 0x7, then load addr 3 → second accept occurs only in IDLE (cycle 3). The load returns 0x7, and req_addr changes after accept do not alter mem_address.
- Reset during load: assert reset in the RWAIT cycle → no rsp_valid, FSM back to INIT. rsp_rdata=0 and the next load works normally.
- LSU_READBACK_EN: store 0x9 to addr 2 with a memory model forcing 0x8 → rsp_valid at cycle 4 with rsp_err=1 and rsp_rdata=0x8. A normal memory gives rsp_err=0.
